ahb_master_busreq_ctrl: RTL

Master-side bus-request controller for the FreeAHB master bench and RTL. It asserts HBUSREQ for a client transfer of N beats and tracks bus ownership from HGRANT/HREADY. It tells the client when each address beat may be driven and re-arbitrates after grant loss or a RETRY/SPLIT response. It is the requesting end of the arbiter handshake, one instance per master (ID ≥ 1).

---
 rtl/ahb_busreq_pkg.sv | 22 ++
 rtl/ahb_beat_counter.sv | 34 +++
 rtl/ahb_master_busreq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ahb_busreq_pkg.sv
// Shared types and constants for the AHB master bus-request controller.
package ahb_busreq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DRAIN
    } busreq_state_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam int unsigned MAX_BEATS = 16;

    function automatic logic [4:0] clamp_beats(input logic [4:0] n);
        return (n > 5'(MAX_BEATS)) ? 5'(MAX_BEATS) : n;
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Remaining-address-beat counter: load with clamp, decrement on accept,
// increment (saturating) when a retried beat must be reissued.
module ahb_beat_counter
    import ahb_busreq_pkg::*;
(
    input  logic       i_hclk,
    input  logic       i_hreset_n,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [4:0] i_load_val,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [4:0] o_count
);

    logic [4:0] count_q;

    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            count_q <= '0;
        end else if (i_clr) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= clamp_beats(i_load_val);
        end else if (i_inc) begin
            count_q <= (count_q >= 5'(MAX_BEATS)) ? 5'(MAX_BEATS) : count_q + 5'd1;
        end else if (i_dec && count_q != '0) begin
            count_q <= count_q - 5'd1;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/ahb_master_busreq_ctrl.sv
// Master-side HBUSREQ controller: requests the bus for an N-beat transfer,
// tracks ownership and re-arbitrates after grant loss or RETRY/SPLIT.
module ahb_master_busreq_ctrl
    import ahb_busreq_pkg::*;
#(
    parameter int unsigned MASTER_ID = 1
) (
    input  logic       i_hclk,
    input  logic       i_hreset_n,
    input  logic       i_start,
    input  logic [4:0] i_beats,
    input  logic       i_hgrant,
    input  logic       i_hready,
    input  logic [1:0] i_hresp,
    input  logic [3:0] i_hmaster,
    output logic       o_hbusreq,
    output logic       o_addr_valid,
    output logic       o_first,
    output logic       o_dphase,
    output logic [4:0] o_remaining,
    output logic       o_done,
    output logic       o_error,
    output logic       o_mismatch
);

    localparam logic [3:0] OWN_ID = 4'(MASTER_ID);

    busreq_state_t state_q;
    logic          own_q;
    logic          first_q;
    logic          dphase_q;
    logic          done_q;
    logic          error_q;
    logic          mismatch_q;
    logic [4:0]    remaining;

    logic addr_valid;
    logic accept;
    logic last_accept;
    logic own_next;
    logic own_fall;
    logic start_ok;
    logic resp_hit;
    logic retry_hit;
    logic error_hit;

    always_comb begin
        addr_valid  = (state_q == XFER) && own_q;
        accept      = addr_valid && i_hready;
        last_accept = accept && (remaining == 5'd1);
        own_next    = i_hready ? i_hgrant : own_q;
        own_fall    = own_q && i_hready && !i_hgrant;
        start_ok    = (state_q == IDLE) && i_start && (i_beats != '0);
        // A retried/errored beat can still be in its data phase after we dropped to REQ.
        resp_hit    = (state_q != IDLE) && dphase_q && !i_hready;
        retry_hit   = resp_hit && (i_hresp == HRESP_RETRY || i_hresp == HRESP_SPLIT);
        error_hit   = resp_hit && (i_hresp == HRESP_ERROR);
    end

    ahb_beat_counter u_beat_counter (
        .i_hclk     (i_hclk),
        .i_hreset_n (i_hreset_n),
        .i_clr      (error_hit),
        .i_load     (start_ok),
        .i_load_val (i_beats),
        .i_inc      (retry_hit),
        .i_dec      (accept),
        .o_count    (remaining)
    );

    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            state_q    <= IDLE;
            own_q      <= 1'b0;
            first_q    <= 1'b0;
            dphase_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;

            if (i_hready) begin
                own_q <= i_hgrant;
            end
            if (accept) begin
                dphase_q <= 1'b1;
                first_q  <= 1'b0;
            end else if (i_hready) begin
                dphase_q <= 1'b0;
            end
            if (own_q && i_hmaster != OWN_ID) begin
                mismatch_q <= 1'b1;
            end

            if (error_hit) begin
                state_q <= IDLE;
                error_q <= 1'b1;
                first_q <= 1'b0;
            end else if (retry_hit) begin
                state_q <= REQ;
                first_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            state_q <= REQ;
                        end
                    end
                    REQ: begin
                        if (own_next) begin
                            state_q <= XFER;
                            first_q <= 1'b1;
                        end
                    end
                    XFER: begin
                        if (last_accept) begin
                            state_q <= DRAIN;
                        end else if (own_fall) begin
                            state_q <= REQ;
                            first_q <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (i_hready && i_hresp == HRESP_OKAY) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_hbusreq    = (state_q == REQ) || ((state_q == XFER) && !last_accept);
    assign o_addr_valid = addr_valid;
    assign o_first      = addr_valid && first_q;
    assign o_dphase     = dphase_q;
    assign o_remaining  = remaining;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_mismatch   = mismatch_q;

endmodule
